// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default framing constants.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DEFAULT_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage1_q, stage1_d;
  logic stage2_q, stage2_d;

  // Next-value logic: a plain two-stage shift.
  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  // Synchronizer flops, preset to RESET_VAL so the line reads idle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= RESET_VAL;
      stage2_q <= RESET_VAL;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/uart_rx_receiver.sv
// UART 8N1 receiver: synchronizes rx_pin, deserializes LSB-first frames and
// exposes the last good byte with sticky ready / frame-error / overrun flags.
module uart_rx_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  input  logic                 clear_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (rx_pin),
    .q    (rx_s)
  );

  // Next-state, sampling and flag logic. clear_rx is applied first so that a
  // byte completing in the same cycle overrides the clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = clear_rx ? 1'b0 : ready_q;
    ferr_d  = clear_rx ? 1'b0 : ferr_q;
    ovr_d   = clear_rx ? 1'b0 : ovr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            ovr_d   = clear_rx ? 1'b0 : (ovr_q | ready_q);
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters, shift register and output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_ready    = ready_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_receiver.sv
// Directed bench for uart_rx_receiver with an 8-clock bit period.
module tb_uart_rx_receiver;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_pin;
  logic       clear_rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  uart_rx_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_pin     (rx_pin),
    .clear_rx   (clear_rx),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drives one frame starting at the current negedge, then a short idle gap.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_pin = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_pin = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_rx = 1'b1;
    @(negedge clk);
    clear_rx = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    rx_pin   = 1'b1;
    clear_rx = 1'b0;
    #1;
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 120 && lat < 0; k++) begin
          @(negedge clk);
          if (rx_ready === 1'b1) lat = k;
        end
      end
    join
    vectors++; if (lat < 74 || lat > 79) begin miscompares++; $display("FAIL basic_latency got=%0d exp=74..79 (-1 = timeout)", lat); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL basic_rx_data got=%h exp=a5", rx_data); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL basic_rx_ready got=%b exp=1", rx_ready); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL basic_frame_error got=%b exp=0", frame_error); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    pulse_clear();
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    vectors++; if (rx_data !== 8'h81) begin miscompares++; $display("FAIL ovr_rx_data got=%h exp=81", rx_data); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL ovr_rx_ready got=%b exp=1", rx_ready); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_overrun got=%b exp=1", overrun); end
    pulse_clear();
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL clr_rx_ready got=%b exp=0", rx_ready); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL clr_overrun got=%b exp=0", overrun); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL clr_frame_error got=%b exp=0", frame_error); end
    vectors++; if (rx_data !== 8'h81) begin miscompares++; $display("FAIL clr_rx_data_held got=%h exp=81", rx_data); end
  endtask

  task automatic test_frame_error();
    send_frame(8'h55, 1'b0);
    vectors++; if (frame_error !== 1'b1) begin miscompares++; $display("FAIL ferr_frame_error got=%b exp=1", frame_error); end
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL ferr_rx_ready got=%b exp=0", rx_ready); end
    vectors++; if (rx_data !== 8'h81) begin miscompares++; $display("FAIL ferr_rx_data_kept got=%h exp=81", rx_data); end
    send_frame(8'h0F, 1'b1);
    vectors++; if (rx_data !== 8'h0F) begin miscompares++; $display("FAIL ferr_next_rx_data got=%h exp=0f", rx_data); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL ferr_next_rx_ready got=%b exp=1", rx_ready); end
    vectors++; if (frame_error !== 1'b1) begin miscompares++; $display("FAIL ferr_sticky got=%b exp=1", frame_error); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ferr_next_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    pulse_clear();
    repeat (2) @(negedge clk);
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
    end
    vectors++; if (busy_cycles < 1 || busy_cycles > 6) begin miscompares++; $display("FAIL glitch_busy_cycles got=%0d exp=1..6", busy_cycles); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL glitch_rx_ready got=%b exp=0", rx_ready); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL glitch_frame_error got=%b exp=0", frame_error); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL glitch_overrun got=%b exp=0", overrun); end
    vectors++; if (rx_data !== 8'h0F) begin miscompares++; $display("FAIL glitch_rx_data got=%h exp=0f", rx_data); end
  endtask

  task automatic test_clear_collision();
    send_frame(8'h99, 1'b1);
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL coll_pre_rx_ready got=%b exp=1", rx_ready); end
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (78) @(negedge clk);
        clear_rx = 1'b1;
        @(negedge clk);
        clear_rx = 1'b0;
      end
    join
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL coll_rx_ready got=%b exp=1", rx_ready); end
    vectors++; if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL coll_rx_data got=%h exp=c3", rx_data); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL coll_overrun got=%b exp=0", overrun); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL coll_frame_error got=%b exp=0", frame_error); end
  endtask

  task automatic test_reset_mid_frame();
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      rx_pin = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx_pin = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #1 reset = 1'b0;
    #1;
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_rx_data got=%h exp=00", rx_data); end
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rx_ready got=%b exp=0", rx_ready); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL mid_rst_frame_error got=%b exp=0", frame_error); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL mid_rst_overrun got=%b exp=0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (CPB * 10) @(negedge clk);
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL mid_no_partial got=%b exp=0", rx_ready); end
    send_frame(8'h12, 1'b1);
    vectors++; if (rx_data !== 8'h12) begin miscompares++; $display("FAIL mid_next_rx_data got=%h exp=12", rx_data); end
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL mid_next_rx_ready got=%b exp=1", rx_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_clear_collision();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a stimulus task never returns.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
